// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment readback path.
// Latency: n/a (package only). Backpressure: n/a.
// Contents: active-low segment codes (bit6=g .. bit0=a), result width and range, sign-kind enum.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int RES_W = 6;
  localparam logic signed [RES_W-1:0] RES_MIN = -6'sd9;
  localparam logic signed [RES_W-1:0] RES_MAX = 6'sd18;

  // What a captured pattern means when it sits on the sign/tens digit.
  typedef enum logic [1:0] {
    SIGN_BLANK = 2'd0,
    SIGN_MINUS = 2'd1,
    SIGN_ONE   = 2'd2,
    SIGN_BAD   = 2'd3
  } sign_kind_t;

endpackage

// File: rtl/seg_pattern_dec.sv
// Combinational decode of one active-low 7-segment pattern.
// Latency: 0 cycles. Backpressure: none (pure function of pat_i).
// Ports: pat_i pattern in; digit_o 0..9 (0 when not a digit); kind_o sign meaning;
//        legal_o set for digits 0..9, MINUS and BLANK.
module seg_pattern_dec
  import seg_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] digit_o,
  output sign_kind_t kind_o,
  output logic       legal_o
);

  always_comb begin
    digit_o = 4'd0;
    kind_o  = SIGN_BAD;
    legal_o = 1'b1;
    case (pat_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1: begin
        digit_o = 4'd1;
        kind_o  = SIGN_ONE;
      end
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_MINUS: kind_o  = SIGN_MINUS;
      SEG_BLANK: kind_o  = SIGN_BLANK;
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Rebuilds the signed calculator result from the multiplexed active-low 7-segment bus.
// Latency: digit sampled at cycle S, frame closes (EMIT) in S+1, valid_o/value_o/err_o visible in S+2.
// Backpressure: none; pure monitor, one valid_o pulse per completed scan frame.
// Ports: an_i anode enables, seg_i segments (both active-low); value_o signed result,
//        valid_o one-cycle update strobe, err_o last frame illegal, stale_o no frame within TIMEOUT.
module seg_capture
  import seg_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int ONES_DIGIT = 0,
  parameter int SIGN_DIGIT = 4,
  parameter int SETTLE     = 4,
  parameter int TIMEOUT    = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIGITS-1:0] an_i,
  input  logic [6:0]        seg_i,
  output logic [RES_W-1:0]  value_o,
  output logic              valid_o,
  output logic              err_o,
  output logic              stale_o
);

  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [3:0]      SETTLE_C  = 4'(SETTLE);
  localparam logic [TW-1:0]   TIMEOUT_C = TW'(TIMEOUT);

  localparam logic [1:0] ST_WAIT_ONES = 2'd0;
  localparam logic [1:0] ST_COLLECT   = 2'd1;
  localparam logic [1:0] ST_EMIT      = 2'd2;

  // ---------------- anode stability tracking ----------------
  logic [DIGITS-1:0] an_q;
  logic [3:0]        cnt_q, cnt_d;
  logic              an_onehot, sample, smp_ones, smp_sign;

  assign an_onehot = $onehot(~an_i);

  // Counter saturates at SETTLE so a held digit is sampled exactly once.
  always_comb begin
    cnt_d = 4'd0;
    if (an_onehot && (an_i == an_q)) begin
      cnt_d = (cnt_q == SETTLE_C) ? cnt_q : 4'(cnt_q + 4'd1);
    end
  end

  // Sample only on the increment that lands on SETTLE; an anode change on that
  // edge forces cnt_d to 0, so it is never sampled.
  assign sample   = (cnt_d == SETTLE_C) && (cnt_q != SETTLE_C);
  assign smp_ones = sample && !an_i[ONES_DIGIT];
  assign smp_sign = sample && !an_i[SIGN_DIGIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      cnt_q <= 4'd0;
    end else begin
      an_q  <= an_i;
      cnt_q <= cnt_d;
    end
  end

  // ---------------- pattern decode of the live segment bus ----------------
  logic [3:0] dec_digit;
  sign_kind_t dec_kind;
  logic       dec_legal;
  logic       dec_ones_ok;

  seg_pattern_dec u_dec (
    .pat_i   (seg_i),
    .digit_o (dec_digit),
    .kind_o  (dec_kind),
    .legal_o (dec_legal)
  );

  // A ones position must show a real digit; BLANK/MINUS there make the frame illegal.
  assign dec_ones_ok = dec_legal && (dec_kind != SIGN_BLANK) && (dec_kind != SIGN_MINUS);

  // ---------------- frame FSM ----------------
  logic [1:0] state_q, state_d;
  logic       got_sign_q, got_sign_d;
  logic [3:0] ones_dig_q, ones_dig_d;
  logic       ones_ok_q, ones_ok_d;
  sign_kind_t sign_q, sign_d;
  logic [3:0] frm_dig_q, frm_dig_d;
  logic       frm_ok_q, frm_ok_d;
  sign_kind_t frm_sign_q, frm_sign_d;

  always_comb begin
    state_d    = state_q;
    got_sign_d = got_sign_q;
    ones_dig_d = ones_dig_q;
    ones_ok_d  = ones_ok_q;
    sign_d     = sign_q;
    frm_dig_d  = frm_dig_q;
    frm_ok_d   = frm_ok_q;
    frm_sign_d = frm_sign_q;
    case (state_q)
      ST_WAIT_ONES: begin
        if (smp_ones) begin
          ones_dig_d = dec_digit;
          ones_ok_d  = dec_ones_ok;
          got_sign_d = 1'b0;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT, ST_EMIT: begin
        // EMIT lasts one cycle; the frame was already snapshotted, so the
        // collect registers keep running underneath it.
        if (state_q == ST_EMIT) begin
          state_d = ST_COLLECT;
        end
        if (smp_ones) begin
          if (got_sign_q && (state_q == ST_COLLECT)) begin
            frm_dig_d  = ones_dig_q;
            frm_ok_d   = ones_ok_q;
            frm_sign_d = sign_q;
            state_d    = ST_EMIT;
          end
          ones_dig_d = dec_digit;
          ones_ok_d  = dec_ones_ok;
          got_sign_d = 1'b0;
        end else if (smp_sign) begin
          sign_d     = dec_kind;
          got_sign_d = 1'b1;
        end
      end
      default: state_d = ST_WAIT_ONES;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT_ONES;
      got_sign_q <= 1'b0;
      ones_dig_q <= 4'd0;
      ones_ok_q  <= 1'b0;
      sign_q     <= SIGN_BAD;
      frm_dig_q  <= 4'd0;
      frm_ok_q   <= 1'b0;
      frm_sign_q <= SIGN_BAD;
    end else begin
      state_q    <= state_d;
      got_sign_q <= got_sign_d;
      ones_dig_q <= ones_dig_d;
      ones_ok_q  <= ones_ok_d;
      sign_q     <= sign_d;
      frm_dig_q  <= frm_dig_d;
      frm_ok_q   <= frm_ok_d;
      frm_sign_q <= frm_sign_d;
    end
  end

  // ---------------- frame evaluation ----------------
  logic             eval_ok;
  logic [RES_W-1:0] eval_val;
  logic [RES_W-1:0] mag;

  assign mag = {2'b00, frm_dig_q};

  always_comb begin
    eval_ok  = 1'b0;
    eval_val = mag;
    case (frm_sign_q)
      SIGN_BLANK: eval_ok = frm_ok_q;
      SIGN_MINUS: begin
        eval_ok  = frm_ok_q && (frm_dig_q != 4'd0);
        eval_val = 6'd0 - mag;
      end
      SIGN_ONE: begin
        eval_ok  = frm_ok_q && (frm_dig_q <= 4'd8);
        eval_val = mag + 6'd10;
      end
      default: eval_ok = 1'b0;
    endcase
  end

  // ---------------- output and stale registers ----------------
  logic [RES_W-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [TW-1:0]    stl_q, stl_d;
  logic             emit;

  assign emit = (state_q == ST_EMIT);

  always_comb begin
    valid_d = emit;
    value_d = value_q;
    err_d   = err_q;
    if (emit) begin
      err_d = !eval_ok;
      if (eval_ok) begin
        value_d = eval_val;
      end
    end
    stl_d = stl_q;
    if (emit) begin
      stl_d = '0;
    end else if (stl_q != TIMEOUT_C) begin
      stl_d = TW'(stl_q + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      stl_q   <= '0;
    end else begin
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      stl_q   <= stl_d;
    end
  end

  assign value_o = value_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign stale_o = (stl_q == TIMEOUT_C);

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: table of scan frames plus hand sequences for
// glitches, SETTLE boundary, latency, stale timeout and mid-frame reset.
module tb_seg_capture;
  import seg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] an;
  logic [6:0] seg;
  logic [5:0] value;
  logic       valid, err, stale;

  int n_vec = 0;
  int n_bad = 0;
  int vcnt  = 0;
  int base;

  always #5 clk = ~clk;

  seg_capture #(
    .DIGITS(8), .ONES_DIGIT(0), .SIGN_DIGIT(4), .SETTLE(4), .TIMEOUT(100)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .an_i    (an),
    .seg_i   (seg),
    .value_o (value),
    .valid_o (valid),
    .err_o   (err),
    .stale_o (stale)
  );

  // Count valid pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid === 1'b1) vcnt <= vcnt + 1;
  end

  typedef struct {
    logic [6:0] sgn;
    logic [6:0] ones;
    int         val;
    logic       err;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input logic [6:0] sgn, input logic [6:0] ones);
    for (int d = 0; d < 8; d++) begin
      an  = ~(8'd1 << d);
      seg = (d == 0) ? ones : ((d == 4) ? sgn : SEG_8);
      step(8);
    end
  endtask

  // Ones anode held only n cycles showing '1', rest of scan normal with blank sign.
  task automatic glitch_scan(input int n);
    an  = ~8'd1;
    seg = SEG_1;
    step(n);
    for (int d = 1; d < 8; d++) begin
      an  = ~(8'd1 << d);
      seg = (d == 4) ? SEG_BLANK : SEG_8;
      step(8);
    end
  endtask

  initial begin
    tbl[0]  = '{SEG_BLANK, SEG_5,     5,             1'b0};
    tbl[1]  = '{SEG_MINUS, SEG_9,     int'(RES_MIN), 1'b0};
    tbl[2]  = '{SEG_1,     SEG_8,     int'(RES_MAX), 1'b0};
    tbl[3]  = '{SEG_1,     SEG_9,     18,            1'b1};
    tbl[4]  = '{SEG_MINUS, SEG_0,     18,            1'b1};
    tbl[5]  = '{SEG_BLANK, SEG_0,     0,             1'b0};
    tbl[6]  = '{SEG_1,     SEG_0,     10,            1'b0};
    tbl[7]  = '{SEG_MINUS, SEG_1,     -1,            1'b0};
    tbl[8]  = '{SEG_BLANK, SEG_BLANK, -1,            1'b1};
    tbl[9]  = '{7'b0000001, SEG_3,    -1,            1'b1};
    tbl[10] = '{SEG_BLANK, SEG_7,     7,             1'b0};
    tbl[11] = '{SEG_BLANK, SEG_7,     7,             1'b0};

    rst_n = 1'b0;
    an    = '1;
    seg   = SEG_BLANK;
    step(3);
    check("reset_value", $signed(value), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_err",   int'(err),   0);
    check("reset_stale", int'(stale), 0);
    rst_n = 1'b1;
    step(1);

    // Each frame is emitted during the ones visit of the following scan.
    for (int i = 0; i < NV; i++) begin
      scan(tbl[i].sgn, tbl[i].ones);
      if (i == 0) begin
        check("first_frame_no_valid", vcnt, 0);
      end else begin
        check($sformatf("vec%0d_count", i - 1), vcnt, i);
        check($sformatf("vec%0d_value", i - 1), $signed(value), tbl[i-1].val);
        check($sformatf("vec%0d_err",   i - 1), int'(err), int'(tbl[i-1].err));
      end
      check($sformatf("vec%0d_stale", i), int'(stale), 0);
    end

    // Short anode glitch (3 cycles) and exactly-SETTLE hold (4 cycles) on ones.
    base = vcnt;
    glitch_scan(3);
    check("glitch3_no_valid", vcnt, base);
    scan(SEG_BLANK, SEG_7);
    check("glitch3_count", vcnt, base + 1);
    check("glitch3_value", $signed(value), tbl[11].val);
    glitch_scan(4);
    check("settle_edge_no_valid", vcnt, base + 1);
    scan(SEG_BLANK, SEG_7);
    check("settle_edge_count", vcnt, base + 2);
    check("settle_edge_value", $signed(value), 7);
    check("settle_edge_err", int'(err), 0);

    // Idle bus long enough to time out.
    base = vcnt;
    an  = '1;
    seg = SEG_BLANK;
    step(110);
    check("idle_stale", int'(stale), 1);
    check("idle_no_valid", vcnt, base);

    // Ones visit closes the held frame: sample in cycle 4, valid in cycle 6.
    an  = ~8'd1;
    seg = SEG_7;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("lat_valid_c%0d", k), int'(valid), (k == 6) ? 1 : 0);
      check($sformatf("lat_stale_c%0d", k), int'(stale), (k < 6) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    check("lat_value", $signed(value), 7);

    // Capture a MINUS sign, then reset before the frame can close.
    for (int d = 1; d <= 4; d++) begin
      an  = ~(8'd1 << d);
      seg = (d == 4) ? SEG_MINUS : SEG_8;
      step(8);
    end
    rst_n = 1'b0;
    #1;
    check("arst_value", $signed(value), 0);
    check("arst_err",   int'(err),   0);
    check("arst_stale", int'(stale), 0);
    step(2);
    @(negedge clk);
    check("arst_hold_valid", int'(valid), 0);
    check("arst_hold_value", $signed(value), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = vcnt;
    scan(SEG_BLANK, SEG_2);
    check("post_rst_first_no_valid", vcnt, base);
    scan(SEG_BLANK, SEG_4);
    check("post_rst_count", vcnt, base + 1);
    check("post_rst_value", $signed(value), 2);
    check("post_rst_err",   int'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
# seg_capture

Display-side readback for the calculator result. Monitors the multiplexed, active-low seven-segment bus (segment lines plus digit anode enables) and reconstructs the signed result it shows. The ones digit carries the magnitude's last digit; the sign digit carries blank, minus or '1'. Sits beside the display scanner as an on-chip checker and as the value source for the UART/debug path. Emits one validated value per complete scan frame.

## Interface
- `DIGITS`, 8: number of anode lines.
- `ONES_DIGIT`, 0: anode index of the ones digit.
- `SIGN_DIGIT`, 4: anode index of the sign/tens digit (5th display).
- `SETTLE`, 4: consecutive stable cycles of a one-hot anode before sampling; range 1..15.
- `TIMEOUT`, 1_000_000: cycles without a completed frame before `stale` sets.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `an`  in  DIGITS  active-low digit enables from the scanner.
- `seg`  in  7  active-low segments, bit6=g … bit0=a.
- `value`  out  6  signed two's-complement result, −9..18.
- `valid`  out  1  one-cycle pulse: `value`/`err` updated.
- `err`  out  1  last frame was illegal (held until next frame).
- `stale`  out  1  no frame completed within TIMEOUT cycles.

## Operation
- Anode tracking: `an` is one-hot-low when exactly one bit is 0. Stability counter increments while `an` is one-hot-low and unchanged from the previous cycle; clears on any change or non-one-hot value (all-high or multiple low).
- Sample: the cycle the counter reaches SETTLE, `seg` is captured for that digit; no further sample until `an` changes. Digits other than ONES_DIGIT/SIGN_DIGIT are ignored.
- Pattern decode: `seg_pattern_dec` maps the codes 0–9 (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000) to a digit, plus MINUS=0111111 and BLANK=1111111; anything else is illegal.
- FSM states:
  - WAIT_ONES (after reset): waits for the first ONES sample.
  - COLLECT: holds the latest ONES and SIGN codes and `got_sign`.
  - A ONES sample in COLLECT with `got_sign`=1 closes the frame (EMIT for one cycle), then reopens COLLECT with the new ONES code and `got_sign`=0.
  - A ONES sample without `got_sign` overwrites the held ONES code; no emit.
- Evaluation of the closed frame (ones digit d):
  - sign BLANK → +d.
  - sign MINUS, d=1..9 → −d.
  - sign '1', d=0..8 → 10+d.
  - Any other combination sets `err`=1 and leaves `value` unchanged: illegal pattern, blank ones, minus with 0, '1' with 9.
- Arithmetic: 6-bit two's complement; −9 = 6'b110111, 18 = 6'b010010.
- Stale counter: clears on every EMIT and saturates at TIMEOUT. `stale` = counter==TIMEOUT.

## Timing
- Reset values: `value`=0, `valid`=0, `err`=0, `stale`=0; FSM=WAIT_ONES; counters=0.
- `rst_n` low mid-frame discards all partial captures immediately (asynchronous).
- Latency: sample at cycle S (counter reaches SETTLE); EMIT in S+1; `valid`, `value` and `err` registered and visible in S+2.
- Glitch tolerance: an anode held fewer than SETTLE cycles is never sampled.
- `an` changing on the same edge the counter would hit SETTLE → no sample; counter restarts.
- Frame emitted only on ONES re-entry; the first frame after reset needs two ONES visits.

## Structure
- Shared package `seg_pkg`:
  - The 12 segment pattern constants.
  - Result width (6) and the MIN/MAX result constants (−9/18).
  - Sign-kind enum (BLANK/MINUS/ONE/BAD).
- Sub-module `seg_pattern_dec`: combinational, 7-bit pattern → 4-bit digit, sign kind, legal flag.
- Top holds the stability counter, FSM, frame registers, evaluation and stale counter.

## Test plan
- Clean scan, SETTLE=4, 8 cycles/digit, ONES=0010010 (5), SIGN=blank, two frames → `valid` pulse, `value`=5, `err`=0.
- SIGN=0111111, ONES=0010000 → `value`=−9 (110111). SIGN=1111001, ONES=0000000 → `value`=18.
- SIGN=1111001, ONES=0010000 (19) → `err`=1, `value` holds previous. SIGN=MINUS, ONES=1000000 (−0) → `err`=1.
- 3-cycle anode glitch on ONES carrying 1111001 amid valid frames showing 7 → no sample, `value` stays 7.
- `an`=all ones for TIMEOUT (set 100) cycles → `stale`=1; next valid frame → `stale`=0 the cycle after EMIT.
- Assert `rst_n` low after the SIGN sample, release, run one frame → no `valid` until two ONES visits; outputs 0 during reset.
